// File: rtl/data_bus_arbiter_if.sv
// Request/response port shared by the CPU and DMA masters of data_bus_arbiter.
interface data_bus_arbiter_if #(
  parameter int unsigned W = 32
) ();
  logic         req;
  logic         we;
  logic [W-1:0] addr;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/data_bus_arbiter.sv
// Arbitrates a single-port synchronous RAM between the CPU data port and a DMA master.
// Build option: DBA_ROUND_ROBIN_EN selects round-robin instead of fixed CPU priority.
module data_bus_arbiter #(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  data_bus_arbiter_if.slave    cpu,
  data_bus_arbiter_if.slave    dma,
  output logic                 cpu_stall_o,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [W-1:0]         mem_wdata_o,
  input  logic [W-1:0]         mem_rdata_i,
  output logic                 err_o,
  output logic                 owner_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          oor_q, oor_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [W-1:0]  mem_wdata_q, mem_wdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic          err_q, err_d;
  logic [W-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic [W-1:0]  dma_rdata_q, dma_rdata_d;

  logic          grant_dma;
  logic          any_req;
  logic          sel_we;
  logic [W-1:0]  sel_addr;
  logic [W-1:0]  sel_wdata;
  logic          sel_oor;
  logic          rdata_live_c;
  logic [W-1:0]  rsp_data_c;
  logic          unused_addr_lsb;

  assign any_req         = cpu.req | dma.req;
  assign unused_addr_lsb = ^{cpu.addr[1:0], dma.addr[1:0]};

`ifdef DBA_ROUND_ROBIN_EN
  // rr_q remembers the last winner; a tie goes to the other master.
  logic rr_q, rr_d;
  assign grant_dma = dma.req & (~cpu.req | ~rr_q);
  assign rr_d      = ((state_q == IDLE) && any_req) ? grant_dma : rr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= 1'b0;
    else      rr_q <= rr_d;
  end
`else
  assign grant_dma = dma.req & ~cpu.req;
`endif

  assign sel_we    = grant_dma ? dma.we    : cpu.we;
  assign sel_addr  = grant_dma ? dma.addr  : cpu.addr;
  assign sel_wdata = grant_dma ? dma.wdata : cpu.wdata;
  assign sel_oor   = |sel_addr[W-1:AW+2];

  // Out-of-range accesses return zero; writes leave rdata untouched.
  assign rdata_live_c = (state_q == RESP) && (~we_q | oor_q);
  assign rsp_data_c   = oor_q ? '0 : mem_rdata_i;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    oor_d       = oor_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    err_d       = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = ACCESS;
          owner_d     = grant_dma;
          we_d        = sel_we;
          oor_d       = sel_oor;
          mem_en_d    = ~sel_oor;
          mem_we_d    = sel_we & ~sel_oor;
          mem_addr_d  = sel_addr[AW+1:2];
          mem_wdata_d = sel_wdata;
        end
      end
      ACCESS: begin
        state_d   = RESP;
        cpu_ack_d = ~owner_q;
        dma_ack_d = owner_q;
        err_d     = oor_q;
      end
      RESP: begin
        state_d = IDLE;
        if (rdata_live_c) begin
          if (owner_q) dma_rdata_d = rsp_data_c;
          else         cpu_rdata_d = rsp_data_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      oor_q       <= oor_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // RAM data only exists in the ack cycle, so read data bypasses the hold register there.
  assign cpu.rdata   = (rdata_live_c && !owner_q) ? rsp_data_c : cpu_rdata_q;
  assign dma.rdata   = (rdata_live_c &&  owner_q) ? rsp_data_c : dma_rdata_q;
  assign cpu.ack     = cpu_ack_q;
  assign dma.ack     = dma_ack_q;
  assign cpu_stall_o = cpu.req & ~cpu_ack_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed self-checking bench for data_bus_arbiter with a behavioural 1-cycle RAM.
module tb_data_bus_arbiter;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 10;

  logic          clk;
  logic          rst;
  logic          cpu_stall;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          err;
  logic          owner;

  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [W-1:0]  pre_data;
  logic [W-1:0]  ram [1024];

  int checks;
  int errors;

  data_bus_arbiter_if #(.W(W)) cpu_if ();
  data_bus_arbiter_if #(.W(W)) dma_if ();

  data_bus_arbiter #(.W(W), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu         (cpu_if.slave),
    .dma         (dma_if.slave),
    .cpu_stall_o (cpu_stall),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .err_o       (err),
    .owner_o     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered read; pre_en lets the bench preload words.
  always @(posedge clk) begin
    if (pre_en) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    tick();
    pre_en   = 1'b0;
  endtask

  task automatic apply_reset;
    cpu_if.req = 1'b0;
    dma_if.req = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    preload(10'd5, 32'hDEADBEEF);
    preload(10'd2, 32'h0);
    checks++; if ({mem_en, mem_we, err, owner, cpu_if.ack, dma_if.ack, cpu_stall} !== 7'b0) begin
      errors++; $display("FAIL rst_ctrl: got %b expected 0000000",
        {mem_en, mem_we, err, owner, cpu_if.ack, dma_if.ack, cpu_stall}); end
    checks++; if ({cpu_if.rdata, dma_if.rdata, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL rst_data: got %h %h %h %h expected all 0",
        cpu_if.rdata, dma_if.rdata, mem_addr, mem_wdata); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read;
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 32'h14; cpu_if.wdata = '0;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL t1_stall_n: got %b expected 1", cpu_stall); end
    tick();
    checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd5}) begin
      errors++; $display("FAIL t1_access: got en=%b we=%b addr=%0d expected en=1 we=0 addr=5", mem_en, mem_we, mem_addr); end
    checks++; if ({cpu_stall, cpu_if.ack} !== 2'b10) begin
      errors++; $display("FAIL t1_stall_n1: got stall=%b ack=%b expected stall=1 ack=0", cpu_stall, cpu_if.ack); end
    tick();
    checks++; if ({cpu_if.ack, cpu_stall, err, owner} !== 4'b1000) begin
      errors++; $display("FAIL t1_resp: got ack=%b stall=%b err=%b owner=%b expected 1 0 0 0", cpu_if.ack, cpu_stall, err, owner); end
    checks++; if (cpu_if.rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t1_rdata: got %h expected deadbeef", cpu_if.rdata); end
    cpu_if.req = 1'b0;
    tick();
    checks++; if ({cpu_if.ack, mem_en, cpu_if.rdata} !== {2'b00, 32'hDEADBEEF}) begin
      errors++; $display("FAIL t1_hold: got ack=%b en=%b rdata=%h expected 0 0 deadbeef", cpu_if.ack, mem_en, cpu_if.rdata); end
  endtask

  task automatic test_dma_write_readback;
    dma_if.req = 1'b1; dma_if.we = 1'b1; dma_if.addr = 32'h40; dma_if.wdata = 32'hA5A5A5A5;
    tick();
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata, owner} !== {1'b1, 1'b1, 10'h10, 32'hA5A5A5A5, 1'b1}) begin
      errors++; $display("FAIL t2_write: got en=%b we=%b addr=%h wdata=%h owner=%b expected 1 1 010 a5a5a5a5 1",
        mem_en, mem_we, mem_addr, mem_wdata, owner); end
    tick();
    checks++; if ({dma_if.ack, cpu_if.ack, dma_if.rdata} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL t2_dma_ack: got dack=%b cack=%b drdata=%h expected 1 0 0", dma_if.ack, cpu_if.ack, dma_if.rdata); end
    dma_if.req = 1'b0;
    tick();
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 32'h40;
    tick();
    tick();
    checks++; if ({cpu_if.ack, cpu_if.rdata} !== {1'b1, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL t2_readback: got ack=%b rdata=%h expected 1 a5a5a5a5", cpu_if.ack, cpu_if.rdata); end
    cpu_if.req = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous;
    logic exp_owner [4];
    int   exp_dma_acks;
    int   dma_acks;
    logic got;
`ifdef DBA_ROUND_ROBIN_EN
    exp_owner = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_dma_acks = 2;
`else
    exp_owner = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_dma_acks = 0;
`endif
    apply_reset();
    dma_acks = 0;
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 32'h14;
    dma_if.req = 1'b1; dma_if.we = 1'b0; dma_if.addr = 32'h40;
    for (int t = 0; t < 4; t++) begin
      got = 1'b0;
      for (int c = 0; c < 6 && !got; c++) begin
        tick();
        if (dma_if.ack) dma_acks++;
        if (cpu_if.ack || dma_if.ack) got = 1'b1;
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL t3_timeout[%0d]: got no ack expected ack within 6 cycles", t); end
      checks++; if (owner !== exp_owner[t]) begin
        errors++; $display("FAIL t3_owner[%0d]: got %b expected %b", t, owner, exp_owner[t]); end
      if (t == 3) begin
        cpu_if.req = 1'b0;
        dma_if.req = 1'b0;
      end
    end
    repeat (4) begin
      tick();
      if (dma_if.ack) dma_acks++;
    end
    checks++; if (dma_acks != exp_dma_acks) begin
      errors++; $display("FAIL t3_dma_acks: got %0d expected %0d", dma_acks, exp_dma_acks); end
    checks++; if (cpu_if.rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t3_cpu_rdata: got %h expected deadbeef", cpu_if.rdata); end
  endtask

  task automatic test_out_of_range;
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 32'h0000_1000;
    tick();
    checks++; if ({mem_en, mem_we} !== 2'b00) begin
      errors++; $display("FAIL t4_en: got en=%b we=%b expected 0 0", mem_en, mem_we); end
    tick();
    checks++; if ({cpu_if.ack, err, cpu_if.rdata} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL t4_resp: got ack=%b err=%b rdata=%h expected 1 1 0", cpu_if.ack, err, cpu_if.rdata); end
    cpu_if.req = 1'b0;
    tick();
    checks++; if ({err, cpu_if.ack, cpu_if.rdata} !== {2'b00, 32'h0}) begin
      errors++; $display("FAIL t4_after: got err=%b ack=%b rdata=%h expected 0 0 0", err, cpu_if.ack, cpu_if.rdata); end
  endtask

  task automatic test_reset_mid_op;
    int dma_acks;
    dma_acks = 0;
    dma_if.req = 1'b1; dma_if.we = 1'b1; dma_if.addr = 32'h8; dma_if.wdata = 32'h12345678;
    tick();
    checks++; if ({mem_en, mem_we} !== 2'b11) begin
      errors++; $display("FAIL t5_access: got en=%b we=%b expected 1 1", mem_en, mem_we); end
    rst = 1'b0;
    #1;
    checks++; if ({mem_en, mem_we} !== 2'b00) begin
      errors++; $display("FAIL t5_async_drop: got en=%b we=%b expected 0 0", mem_en, mem_we); end
    dma_if.req = 1'b0;
    tick();
    if (dma_if.ack) dma_acks++;
    rst = 1'b1;
    repeat (3) begin
      tick();
      if (dma_if.ack) dma_acks++;
    end
    checks++; if (dma_acks != 0) begin errors++; $display("FAIL t5_no_ack: got %0d acks expected 0", dma_acks); end
    checks++; if (ram[2] !== 32'h0) begin errors++; $display("FAIL t5_ram: got %h expected 0", ram[2]); end
    checks++; if ({mem_en, owner} !== 2'b00) begin
      errors++; $display("FAIL t5_idle: got en=%b owner=%b expected 0 0", mem_en, owner); end
  endtask

  task automatic test_req_drop;
    int extra;
    extra = 0;
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 32'h40;
    tick();
    cpu_if.req = 1'b0;
    tick();
    checks++; if ({cpu_if.ack, cpu_if.rdata} !== {1'b1, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL t6_ack: got ack=%b rdata=%h expected 1 a5a5a5a5", cpu_if.ack, cpu_if.rdata); end
    repeat (4) begin
      tick();
      if (mem_en || cpu_if.ack) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL t6_no_second: got %0d busy cycles expected 0", extra); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
    dma_if.req = 1'b0; dma_if.we = 1'b0; dma_if.addr = '0; dma_if.wdata = '0;
    test_reset();
    test_cpu_read();
    test_dma_write_readback();
    test_simultaneous();
    test_out_of_range();
    test_reset_mid_op();
    test_req_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
